// File: rtl/alu_sequencer.sv
// alu_sequencer: issue-side controller for the 32-bit combinational ALU.
// Takes one op request at a time over valid/ready, drives the ALU from
// registered operands, and holds the captured result and flags in a
// response register until writeback takes it.
//
// Optional feature macro: ALU_SEQ_MUL_EN
//   Defined:     unsigned WIDTHxWIDTH -> 2*WIDTH multiply, run as WIDTH
//                shift-add iterations on the ALU adder (MUL state).
//   Not defined: no MUL state or registers; req_mul is ignored and every
//                request executes as a single ALU op; rsp_hi is always 0.
//
// Handshake semantics (both ports): a transfer happens on a rising edge
// where valid and ready are both high. req_ready is high only in IDLE, so
// exactly one op is in flight. rsp_valid stays high with rsp_* stable until
// the edge where rsp_ready is also high; only then is a new request taken.
`timescale 1ns/1ps

module alu_sequencer #(
    parameter int         WIDTH  = 32,
    parameter logic [4:0] ADD_OP = 5'b00000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic             req_mul,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_n,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic [WIDTH-1:0] rsp_hi,
    output logic             rsp_z,
    output logic             rsp_v,
    output logic             rsp_n
);

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2,
        S_MUL  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;
`endif

    state_t state;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    // During MUL, alu_a is the high accumulator word itself; lo holds the
    // low product bits shifting in over the remaining multiplier bits.
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mc;
    logic [CW-1:0]    cnt;

    logic             carry;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;

    // Carry-out of the ALU add recovered from operand and result MSBs, then
    // the {carry, y, lo} triple shifted right by one for the next step.
    always_comb begin
        carry  = (alu_a[WIDTH-1] & alu_b[WIDTH-1]) |
                 ((alu_a[WIDTH-1] | alu_b[WIDTH-1]) & ~alu_y[WIDTH-1]);
        hi_nxt = {carry, alu_y[WIDTH-1:1]};
        lo_nxt = {alu_y[0], lo[WIDTH-1:1]};
    end
`else
    logic unused_req_mul;
    assign unused_req_mul = req_mul;
`endif

    // Sequencer FSM with registered ALU drive and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_hi    <= '0;
            rsp_z     <= 1'b0;
            rsp_v     <= 1'b0;
            rsp_n     <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
`ifdef ALU_SEQ_MUL_EN
            lo        <= '0;
            mc        <= '0;
            cnt       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // req_ready is high in IDLE, so req_valid alone means accept.
                    if (req_valid) begin
                        req_ready <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
                        if (req_mul) begin
                            state  <= S_MUL;
                            cnt    <= '0;
                            mc     <= req_a;
                            lo     <= req_b;
                            alu_a  <= '0;
                            alu_b  <= req_b[0] ? req_a : '0;
                            alu_op <= ADD_OP;
                        end else begin
                            state  <= S_EXEC;
                            alu_a  <= req_a;
                            alu_b  <= req_b;
                            alu_op <= req_op;
                        end
`else
                        state  <= S_EXEC;
                        alu_a  <= req_a;
                        alu_b  <= req_b;
                        alu_op <= req_op;
`endif
                    end
                end

                S_EXEC: begin
                    rsp_y     <= alu_y;
                    rsp_hi    <= '0;
                    rsp_z     <= alu_z;
                    rsp_v     <= alu_v;
                    rsp_n     <= alu_n;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end

`ifdef ALU_SEQ_MUL_EN
                S_MUL: begin
                    alu_a <= hi_nxt;
                    lo    <= lo_nxt;
                    alu_b <= lo_nxt[0] ? mc : '0;
                    if (cnt == LAST_ITER) begin
                        rsp_hi    <= hi_nxt;
                        rsp_y     <= lo_nxt;
                        rsp_z     <= ({hi_nxt, lo_nxt} == '0);
                        rsp_v     <= (hi_nxt != '0);
                        rsp_n     <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: bench for alu_sequencer with a behavioural ALU attached.
// Covers reset state, a table of directed ops (flag corners, multiply
// corners or ignored req_mul depending on ALU_SEQ_MUL_EN), a response stall
// with a pending request, reset during a multiply, and random traffic
// checked against arithmetic reference results.
`timescale 1ns/1ps

module tb_alu_sequencer;

    localparam int         WIDTH  = 32;
    localparam logic [4:0] ADD_OP = 5'b00000;
    localparam int         RW     = 2 * WIDTH + 3;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [4:0]       req_op;
    logic             req_mul;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [4:0]       alu_op;
    logic [WIDTH-1:0] alu_y;
    logic             alu_z;
    logic             alu_v;
    logic             alu_n;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic [WIDTH-1:0] rsp_hi;
    logic             rsp_z;
    logic             rsp_v;
    logic             rsp_n;

    logic [RW-1:0] rsp_all;
    assign rsp_all = {rsp_hi, rsp_y, rsp_z, rsp_v, rsp_n};

    alu_sequencer #(.WIDTH(WIDTH), .ADD_OP(ADD_OP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_mul   (req_mul),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_y     (alu_y),
        .alu_z     (alu_z),
        .alu_v     (alu_v),
        .alu_n     (alu_n),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_hi    (rsp_hi),
        .rsp_z     (rsp_z),
        .rsp_v     (rsp_v),
        .rsp_n     (rsp_n)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural ALU ----------------
    // Arith (op[4]=0): op[0]=0 add, op[0]=1 subtract, v = signed overflow.
    // Bool  (op[4]=1): op[1:0] selects and/or/xor/nor, v = 0.
    // Returns {y, z, v, n}.
    function automatic logic [WIDTH+2:0] alu_ref(input logic [4:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] y;
        logic             v;
        longint           s;
        v = 1'b0;
        if (!op[4]) begin
            s = op[0] ? (longint'($signed(a)) - longint'($signed(b)))
                      : (longint'($signed(a)) + longint'($signed(b)));
            y = op[0] ? (a - b) : (a + b);
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else begin
            case (op[1:0])
                2'd0:    y = a & b;
                2'd1:    y = a | b;
                2'd2:    y = a ^ b;
                default: y = ~(a | b);
            endcase
        end
        return {y, (y == '0), v, y[WIDTH-1]};
    endfunction

    always_comb begin
        {alu_y, alu_z, alu_v, alu_n} = alu_ref(alu_op, alu_a, alu_b);
    end

    // ---------------- reference model ----------------
    function automatic logic [RW-1:0] mk(input logic [WIDTH-1:0] hi, input logic [WIDTH-1:0] y,
                                         input logic z, input logic v, input logic n);
        return {hi, y, z, v, n};
    endfunction

    function automatic bit mul_on(input logic mul);
`ifdef ALU_SEQ_MUL_EN
        return mul;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [RW-1:0] expect_rsp(input logic [4:0] op, input logic mul,
                                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] p;
        if (mul_on(mul)) begin
            p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
            return mk(p[2*WIDTH-1:WIDTH], p[WIDTH-1:0], (p == '0), (p[2*WIDTH-1:WIDTH] != '0), 1'b0);
        end
        return {{WIDTH{1'b0}}, alu_ref(op, a, b)};
    endfunction

    // Edges from the accept edge to the edge after which rsp_valid is high.
    function automatic int exp_lat(input logic mul);
        return mul_on(mul) ? WIDTH : 1;
    endfunction

    // ---------------- scoreboard ----------------
    int            n_checks;
    int            n_pass;
    logic [RW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [4:0] op, input logic mul,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int waited;
        waited    = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_mul   = mul;
        req_a     = a;
        req_b     = b;
        while (!req_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("req_ready_before_accept", RW'(req_ready), RW'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake(input string name);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({name, "_rsp_valid_after_hs"}, RW'(rsp_valid), RW'(0));
        chk({name, "_req_ready_after_hs"}, RW'(req_ready), RW'(1));
    endtask

    task automatic run_txn(input logic [4:0] op, input logic mul,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [RW-1:0] exp, input int hold, input string name);
        int            lat;
        logic [RW-1:0] e;
        exp_q.push_back(exp);
        send(op, mul, a, b);
        chk({name, "_req_ready_busy"}, RW'(req_ready), RW'(0));
        wait_rsp(lat);
        chk({name, "_latency"}, RW'(lat), RW'(exp_lat(mul)));
        e = exp_q.pop_front();
        chk({name, "_result"}, rsp_all, e);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk({name, "_hold_result"}, rsp_all, e);
            chk({name, "_hold_valid"}, RW'(rsp_valid), RW'(1));
            chk({name, "_hold_req_ready"}, RW'(req_ready), RW'(0));
        end
        handshake(name);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [4:0]       op;
        logic             mul;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [RW-1:0]    exp;
    } vec_t;

    vec_t vec_q[$];

    task automatic add_vec(input logic [4:0] op, input logic mul, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [RW-1:0] exp);
        vec_t v;
        v.op  = op;
        v.mul = mul;
        v.a   = a;
        v.b   = b;
        v.exp = exp;
        vec_q.push_back(v);
    endtask

    logic [4:0] ops[6];

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int            lat;
        logic [RW-1:0] e;
        logic [4:0]    op;
        logic          mul;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;

        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_mul   = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        ops[0] = 5'b00000; ops[1] = 5'b00001; ops[2] = 5'b10000;
        ops[3] = 5'b10001; ops[4] = 5'b10010; ops[5] = 5'b10011;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", RW'(req_ready), RW'(1));
        chk("reset_rsp_valid", RW'(rsp_valid), RW'(0));
        chk("reset_rsp", rsp_all, '0);
        chk("reset_alu_drive", RW'({alu_a, alu_b, alu_op}), '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors: {op, mul, a, b} -> {hi, y, z, v, n}
        add_vec(ADD_OP,   1'b0, 32'd5,          32'd7,          mk(0, 32'd12,        0, 0, 0));
        add_vec(5'b00001, 1'b0, 32'd5,          32'd5,          mk(0, 32'd0,         1, 0, 0));
        add_vec(ADD_OP,   1'b0, 32'h7FFF_FFFF,  32'd1,          mk(0, 32'h8000_0000, 0, 1, 1));
        add_vec(5'b00001, 1'b0, 32'd0,          32'd1,          mk(0, 32'hFFFF_FFFF, 0, 0, 1));
        add_vec(ADD_OP,   1'b0, 32'hFFFF_FFFF,  32'd1,          mk(0, 32'd0,         1, 0, 0));
        add_vec(5'b10000, 1'b0, 32'hF0F0_F0F0,  32'hFF00_FF00,  mk(0, 32'hF000_F000, 0, 0, 1));
        add_vec(5'b10001, 1'b0, 32'd0,          32'd0,          mk(0, 32'd0,         1, 0, 0));
        add_vec(5'b10010, 1'b0, 32'hAAAA_AAAA,  32'h5555_5555,  mk(0, 32'hFFFF_FFFF, 0, 0, 1));
        add_vec(5'b10011, 1'b0, 32'd0,          32'd0,          mk(0, 32'hFFFF_FFFF, 0, 0, 1));
`ifdef ALU_SEQ_MUL_EN
        add_vec(ADD_OP,   1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  mk(32'hFFFF_FFFE, 32'h0000_0001, 0, 1, 0));
        add_vec(ADD_OP,   1'b1, 32'd0,          32'd123,        mk(0, 32'd0,         1, 0, 0));
        add_vec(ADD_OP,   1'b1, 32'd6,          32'd7,          mk(0, 32'd42,        0, 0, 0));
        add_vec(ADD_OP,   1'b1, 32'h0001_0000,  32'h0001_0000,  mk(32'd1, 32'd0,     0, 1, 0));
`else
        add_vec(ADD_OP,   1'b1, 32'd3,          32'd4,          mk(0, 32'd7,         0, 0, 0));
        add_vec(5'b10000, 1'b1, 32'hFFFF_0000,  32'h0FF0_0FF0,  mk(0, 32'h0FF0_0000, 0, 0, 0));
`endif
        foreach (vec_q[i]) begin
            run_txn(vec_q[i].op, vec_q[i].mul, vec_q[i].a, vec_q[i].b, vec_q[i].exp,
                    i % 3, $sformatf("vec%0d", i));
        end

        // Response stall of 5 cycles with the next request already waiting
        exp_q.push_back(mk(0, 32'd30, 0, 0, 0));
        send(ADD_OP, 1'b0, 32'd10, 32'd20);
        wait_rsp(lat);
        chk("stall_latency", RW'(lat), RW'(1));
        e = exp_q.pop_front();
        req_valid = 1'b1;
        req_op    = ADD_OP;
        req_mul   = 1'b0;
        req_a     = 32'd1;
        req_b     = 32'd2;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("stall_result", rsp_all, e);
            chk("stall_valid", RW'(rsp_valid), RW'(1));
            chk("stall_req_ready", RW'(req_ready), RW'(0));
        end
        handshake("stall");
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("stall_next_accepted", RW'(req_ready), RW'(0));
        exp_q.push_back(mk(0, 32'd3, 0, 0, 0));
        wait_rsp(lat);
        chk("stall_next_latency", RW'(lat), RW'(1));
        chk("stall_next_result", rsp_all, exp_q.pop_front());
        handshake("stall_next");

`ifdef ALU_SEQ_MUL_EN
        // Reset in the middle of a multiply aborts it silently
        send(ADD_OP, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("mulrst_busy", RW'(rsp_valid), RW'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("mulrst_req_ready", RW'(req_ready), RW'(1));
        chk("mulrst_rsp_valid", RW'(rsp_valid), RW'(0));
        chk("mulrst_rsp", rsp_all, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mulrst_idle", RW'({req_ready, rsp_valid}), RW'(2'b10));
        run_txn(ADD_OP, 1'b1, 32'd6, 32'd7, mk(0, 32'd42, 0, 0, 0), 1, "mulrst_next");
`endif

        // Random traffic against the reference model
        for (int i = 0; i < 30; i++) begin
            op  = ops[$urandom_range(0, 5)];
            mul = ($urandom_range(0, 2) == 0);
            a   = pick();
            b   = pick();
            run_txn(op, mul, a, b, expect_rsp(op, mul, a, b), $urandom_range(0, 3),
                    $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
